// File: rtl/mc_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath; outputs decode combinationally from state, opcode and mem_ready.
// 3 to 5 cycles per instruction; FETCH, MEMRD and MEMWR hold while mem_ready is low.
module mc_main_control #(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           branch_ne,
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_src,
  output logic           ext_sign,
  output logic           instr_done,
  output logic           illegal_op,
  output logic [3:0]     state
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEMADR  = 4'd3;
  localparam logic [3:0] S_MEMRD   = 4'd4;
  localparam logic [3:0] S_MEMWB   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_REX     = 4'd7;
  localparam logic [3:0] S_RWB     = 4'd8;
  localparam logic [3:0] S_BREX    = 4'd9;
  localparam logic [3:0] S_IMMEX   = 4'd10;
  localparam logic [3:0] S_IMMWB   = 4'd11;
  localparam logic [3:0] S_JEX     = 4'd12;
  localparam logic [3:0] S_ILLEGAL = 4'd13;

  localparam logic [OPW-1:0] OP_R    = 6'b000000;
  localparam logic [OPW-1:0] OP_LW   = 6'b100011;
  localparam logic [OPW-1:0] OP_SW   = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE  = 6'b000101;
  localparam logic [OPW-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPW-1:0] OP_ANDI = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI  = 6'b001101;
  localparam logic [OPW-1:0] OP_J    = 6'b000010;

  logic [3:0] state_q;
  logic [3:0] state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  assign state = state_q;

  always_comb begin
    state_nxt = S_IDLE;
    case (state_q)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:             state_nxt = S_MEMADR;
          OP_R:                     state_nxt = S_REX;
          OP_BEQ, OP_BNE:           state_nxt = S_BREX;
          OP_ADDI, OP_ANDI, OP_ORI: state_nxt = S_IMMEX;
          OP_J:                     state_nxt = S_JEX;
          default:                  state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_REX:    state_nxt = S_RWB;
      S_IMMEX:  state_nxt = S_IMMWB;
      S_MEMWB, S_RWB, S_BREX, S_IMMWB, S_JEX, S_ILLEGAL: state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    ext_sign      = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      // Branch target is precomputed here while the register file is read.
      S_DECODE: begin
        alu_src_b = 2'b11;
        ext_sign  = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_sign  = 1'b1;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_REX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BREX: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_src        = 2'b01;
        pc_write_cond = 1'b1;
        branch_ne     = (opcode == OP_BNE);
        instr_done    = 1'b1;
      end
      // Logical immediates are zero-extended and use the opcode-driven ALU decode.
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_sign  = (opcode == OP_ADDI);
        alu_op    = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
      end
      S_IMMWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JEX: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: instruction-path model checked every cycle plus literal latency/trace checks.
module tb_mc_main_control;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       ext_sign, instr_done, illegal_op;
  } out_t;

  logic       clk, rst_n, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_sign, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  mc_main_control #(.OPW(6)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .ext_sign(ext_sign), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0]  m_state;
  logic [11:0] pend;
  int          npend;
  out_t        smp;
  logic [31:0] trace;
  int cnt_regw, cnt_memw, cnt_ill;

  function automatic out_t dut_out();
    out_t o;
    o = '{state, pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
          mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
          ext_sign, instr_done, illegal_op};
    return o;
  endfunction

  // What each step of an instruction must drive, by role.
  function automatic out_t exp_out(logic [3:0] st, logic [5:0] op, logic rdy);
    out_t e;
    e = '0;
    e.state = st;
    case (st)
      4'd1:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      4'd2:  begin e.alu_src_b = 2'b11; e.ext_sign = 1; end
      4'd3:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.ext_sign = 1; end
      4'd4:  begin e.mem_read = 1; e.iord = 1; end
      4'd5:  begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
      4'd6:  begin e.mem_write = 1; e.iord = 1; e.instr_done = rdy; end
      4'd7:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      4'd8:  begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
      4'd9:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_write_cond = 1;
                   e.branch_ne = (op == 6'b000101); e.instr_done = 1; end
      4'd10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10;
                   e.ext_sign = (op == 6'b001000);
                   e.alu_op = (op == 6'b001000) ? 2'b00 : 2'b11; end
      4'd11: begin e.reg_write = 1; e.instr_done = 1; end
      4'd12: begin e.pc_write = 1; e.pc_src = 2'b10; e.instr_done = 1; end
      4'd13: begin e.illegal_op = 1; e.instr_done = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: each opcode maps to the list of steps after DECODE; memory steps wait for ready.
  task automatic model_step();
    logic [11:0] p;
    int n;
    if (!rst_n) begin
      m_state = 4'd0; npend = 0;
    end else begin
      case (m_state)
        4'd0: m_state = 4'd1;
        4'd1: if (mem_ready) m_state = 4'd2;
        4'd2: begin
          case (opcode)
            6'b100011: begin p = 12'h345; n = 3; end
            6'b101011: begin p = 12'h360; n = 2; end
            6'b000000: begin p = 12'h780; n = 2; end
            6'b000100, 6'b000101: begin p = 12'h900; n = 1; end
            6'b001000, 6'b001100, 6'b001101: begin p = 12'hAB0; n = 2; end
            6'b000010: begin p = 12'hC00; n = 1; end
            default:   begin p = 12'hD00; n = 1; end
          endcase
          m_state = p[11:8]; pend = p << 4; npend = n - 1;
        end
        default: begin
          if ((m_state == 4'd4 || m_state == 4'd6) && !mem_ready) begin
          end else if (npend == 0) begin
            m_state = 4'd1;
          end else begin
            m_state = pend[11:8]; pend = pend << 4; npend--;
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    smp = dut_out();
    chk("outputs", 32'(smp), 32'(exp_out(m_state, opcode, mem_ready)));
    chk("rd_wr_excl", {31'd0, smp.mem_read & smp.mem_write}, 32'd0);
    chk("regw_pcw_excl", {31'd0, smp.reg_write & (smp.pc_write | smp.pc_write_cond)}, 32'd0);
    trace = {trace[27:0], smp.state};
    cnt_regw += int'(smp.reg_write);
    cnt_memw += int'(smp.mem_write);
    cnt_ill  += int'(smp.illegal_op);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, output int lat);
    bit done;
    lat = 0; done = 0;
    while (!done && lat < 64) begin
      opcode = op;
      if (m_state == 4'd1 && fw > 0) begin mem_ready = 0; fw--; end
      else if ((m_state == 4'd4 || m_state == 4'd6) && mw > 0) begin mem_ready = 0; mw--; end
      else mem_ready = 1;
      tick();
      lat++;
      done = smp.instr_done;
    end
    if (!done) chk("instr_done_timeout", 32'(lat), 32'd0);
  endtask

  initial begin
    int lat, r0, w0, i0;
    rst_n = 0; mem_ready = 0; opcode = 6'd0;
    m_state = 0; pend = 0; npend = 0; trace = 0;
    cnt_regw = 0; cnt_memw = 0; cnt_ill = 0;
    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outputs", 32'(dut_out()), 32'd0);
    tick(); tick();
    rst_n = 1;
    tick();
    chk("idle_after_reset", 32'(smp.state), 32'd0);

    r0 = cnt_regw;
    run_instr(6'b100011, 0, 0, lat);
    chk("lw_latency", 32'(lat), 32'd5);
    chk("lw_trace", {12'd0, trace[19:0]}, 32'h00012345);
    chk("lw_regw_cycles", 32'(cnt_regw - r0), 32'd1);

    r0 = cnt_regw; w0 = cnt_memw;
    run_instr(6'b101011, 0, 2, lat);
    chk("sw_wait_latency", 32'(lat), 32'd6);
    chk("sw_memw_cycles", 32'(cnt_memw - w0), 32'd3);
    chk("sw_no_regw", 32'(cnt_regw - r0), 32'd0);

    run_instr(6'b001101, 0, 0, lat); chk("ori_latency", 32'(lat), 32'd4);
    run_instr(6'b001000, 0, 0, lat); chk("addi_latency", 32'(lat), 32'd4);
    run_instr(6'b000101, 0, 0, lat); chk("bne_latency", 32'(lat), 32'd3);
    run_instr(6'b000100, 0, 0, lat); chk("beq_latency", 32'(lat), 32'd3);
    run_instr(6'b000000, 0, 0, lat); chk("r_latency", 32'(lat), 32'd4);
    run_instr(6'b000010, 0, 0, lat); chk("j_latency", 32'(lat), 32'd3);

    r0 = cnt_regw; w0 = cnt_memw; i0 = cnt_ill;
    run_instr(6'b111111, 0, 0, lat);
    chk("ill_latency", 32'(lat), 32'd3);
    chk("ill_trace", {20'd0, trace[11:0]}, 32'h0000012D);
    chk("ill_pulses", 32'(cnt_ill - i0), 32'd1);
    chk("ill_no_writes", 32'((cnt_regw - r0) + (cnt_memw - w0)), 32'd0);

    run_instr(6'b100011, 1, 1, lat); chk("lw_wait_latency", 32'(lat), 32'd7);
    run_instr(6'b001100, 0, 0, lat); chk("andi_latency", 32'(lat), 32'd4);

    // Reset asserted mid-cycle while a load waits in MEMRD.
    opcode = 6'b100011; mem_ready = 1;
    tick(); tick(); tick();
    mem_ready = 0;
    chk("pre_reset_memrd", 32'(state), 32'd4);
    #2;
    rst_n = 0; m_state = 0; npend = 0;
    #1;
    chk("async_reset_state", 32'(state), 32'd0);
    chk("async_reset_outputs", 32'(dut_out()), 32'd0);
    tick(); tick(); tick();
    rst_n = 1;
    tick();
    chk("post_reset_idle", 32'(smp.state), 32'd0);
    tick();
    chk("post_reset_fetch", 32'(smp.state), 32'd1);
    chk("post_reset_mem_read", 32'(smp.mem_read), 32'd1);

    run_instr(6'b101011, 0, 0, lat); chk("sw_latency", 32'(lat), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Main control FSM for the multi-cycle 32-bit MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath strobe and mux select.
- Drives the sign/zero-extend select (ext_sign) of the 16->32-bit immediate extender.
- Stalls on a single-port unified memory via a ready handshake.

Parameters:
- OPW, 6, opcode field width (instr[31:26]); fixed encodings below assume 6.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; stable outside FETCH
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if branch condition true
- branch_ne  out  1  condition is ALU-zero==0 (bne), else zero==1
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  writeback source: 1=MDR, 0=ALUOut
- reg_dst  out  1  dest: 1=rd, 0=rt
- reg_write  out  1  register file write
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=ext imm, 11=ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct decode, 11=logical-imm (ALU decoder uses opcode)
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ext_sign  out  1  1=sign-extend imm, 0=zero-extend
- instr_done  out  1  one-cycle pulse on final cycle of each instruction
- illegal_op  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state, for debug

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, andi=001100, ori=001101, j=000010.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REX=7, RWB=8, BREX=9, IMMEX=10, IMMWB=11, JEX=12, ILLEGAL=13. Codes 14-15 go to IDLE.
- Outputs are decoded combinationally from state, opcode and mem_ready. Any strobe not listed for a state is 0; mux selects not listed are 0.
- rst_n low: state=IDLE immediately, regardless of clk. All outputs 0, state=0. Any in-flight instruction is abandoned, with no strobe asserted.
- IDLE: all outputs 0; next state FETCH unconditionally.
- FETCH: mem_read=1, iord=0, alu_src_b=01, alu_op=00.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alu_src_b=11, ext_sign=1, alu_op=00 (branch target precompute). Next state by opcode:
  - lw/sw -> MEMADR
  - R -> REX
  - beq/bne -> BREX
  - addi/andi/ori -> IMMEX
  - j -> JEX
  - other -> ILLEGAL
- MEMADR: alu_src_a=1, alu_src_b=10, ext_sign=1. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; next FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready=1; in that cycle instr_done=1 and next state is FETCH.
- REX: alu_src_a=1, alu_src_b=00, alu_op=10; next RWB.
- RWB: reg_write=1, reg_dst=1, instr_done=1; next FETCH.
- BREX: alu_src_a=1, alu_op=01, pc_src=01, pc_write_cond=1, branch_ne=(opcode==bne), instr_done=1; next FETCH.
- IMMEX: alu_src_a=1, alu_src_b=10.
  - addi: ext_sign=1, alu_op=00.
  - andi/ori: ext_sign=0, alu_op=11.
  - Next IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; next FETCH.
- JEX: pc_write=1, pc_src=10, instr_done=1; next FETCH.
- ILLEGAL: illegal_op=1, instr_done=1; next FETCH. The instruction is skipped; PC was already advanced in FETCH.
- Instruction latency with mem_ready tied to 1:
  - lw: 5 cycles
  - sw, R, addi/andi/ori: 4 cycles
  - beq/bne, j, illegal: 3 cycles
  - Each memory-wait cycle adds 1.
- mem_read and mem_write are never both 1. reg_write and any PC write are never both 1.

Test Plan:
- Hold rst_n=0 for 3 cycles mid-MEMRD, then release -> outputs 0 immediately on assertion; IDLE for 1 cycle after release, then FETCH with mem_read=1.
- lw (100011), mem_ready=1 always -> states 1,2,3,4,5; reg_write=1 and mem_to_reg=1 only in MEMWB; instr_done pulse at cycle 5.
- sw with mem_ready low for 2 cycles in MEMWR -> mem_write=1, iord=1 held 3 cycles; no reg_write; instr_done only on the ready cycle.
- ori (001101) then addi (001000) -> ext_sign=0 with alu_op=11 in IMMEX for ori; ext_sign=1 with alu_op=00 for addi.
- bne (000101) -> BREX has pc_write_cond=1, branch_ne=1, pc_src=01. beq -> same but branch_ne=0.
- opcode 111111 -> illegal_op pulses once in state 13, then returns to FETCH; no register or memory write occurs.
